execute_stage: RTL and testbench
================================

# execute_stage

Execute (E) stage of the pipelined Y86-64 processor. Sits between the D→E pipeline register and the memory stage. It selects ALU operands and function from the instruction fields, computes valE, and maintains the condition-code register. It evaluates the branch/cmov condition and latches results into the E→M pipeline register. It also exports unregistered forwarding values (e_valE, e_dstE) to decode.

## Interface
Parameters:
- W, 64, datapath width.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high.
- E_stat  input  3  status of instruction in E (AOK=1, HLT=2, ADR=3, INS=4).
- E_icode  input  4  instruction code.
- E_ifun  input  4  function code.
- E_valA, E_valB, E_valC  input  W  operands.
- E_dstE, E_dstM  input  4  destination register IDs (RNONE=0xF).
- m_exc  input  1  memory-stage instruction is excepting (stat ∉ {AOK}).
- W_exc  input  1  write-back-stage instruction is excepting.
- M_stall  input  1  hold the E→M register.
- M_bubble  input  1  load a nop bubble into the E→M register.
- e_valE  output  W  combinational ALU result, for forwarding.
- e_dstE  output  4  combinational effective dstE, for forwarding.
- e_cnd  output  1  combinational condition result.
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  output  —  registered E→M fields; widths as inputs.
- cc  output  3  registered {ZF, SF, OF}.

## Operation
- aluA:
  - valA for icode 2 (rrmovq/cmov) and 6 (OPq).
  - valC for 3, 4, 5.
  - −8 for 8 (call) and A (push).
  - +8 for 9 (ret) and B (pop).
  - 0 otherwise.
- aluB:
  - valB for 4, 5, 6, 8, 9, A, B.
  - 0 for 2, 3 and all other codes.
- alufun: ifun when icode=6, else ADD.
- Supported alufun values: 0 ADD = B+A; 1 SUB = B−A; 2 AND; 3 XOR. Codes 4–F give valE=0.
- All arithmetic is W-bit two's complement. Wrap-around is silent; no trap.
- Flags are computed from the ALU result:
  - ZF = (valE==0).
  - SF = valE[W−1].
  - OF, ADD: both operands have the same sign and the result sign differs.
  - OF, SUB: B and A have different signs and the result sign ≠ B's sign.
  - OF, AND/XOR: 0.
- CC updates only when icode=6, E_stat=AOK, !m_exc and !W_exc.
- e_cnd is taken from the current registered cc, for icode 2 and 7 only, by ifun:
  - 0 → 1
  - 1 (le) → (SF^OF)|ZF
  - 2 (l) → SF^OF
  - 3 (e) → ZF
  - 4 (ne) → !ZF
  - 5 (ge) → !(SF^OF)
  - 6 (g) → !(SF^OF)&!ZF
  - ifun >6 → 0
  - any other icode → 0
- e_dstE = RNONE when icode=2 and !e_cnd; otherwise E_dstE.
- E→M register priority, evaluated at each clock edge:
  - reset: load the bubble.
  - else M_stall: hold all fields.
  - else M_bubble: load the bubble.
  - else: load {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM}.
- Bubble value: stat=AOK, icode=1 (nop), cnd=0, valE=0, valA=0, dstE=dstM=0xF.
- cc reset value: {ZF=1, SF=0, OF=0}.
- CC updates ignore M_stall/M_bubble: only the update conditions above apply.

## Timing
- 1-cycle latency from E inputs to M_* outputs.
- e_valE, e_dstE and e_cnd are combinational in the same cycle as the E inputs.
- A CC update at edge t is visible to e_cnd from cycle t+1. A cmov/jXX directly behind an OPq therefore sees the new flags, because they occupy adjacent cycles.
- Reset asserted mid-stream: at the next edge, M = bubble and cc = reset value, regardless of stall, bubble or update conditions.
- Stall and bubble asserted together: stall wins.
- m_exc or W_exc asserted in the same cycle as an OPq: valE is still computed and registered; CC is unchanged.

## Structure
- Package y86_pkg holds:
  - icode constants (IHALT…IPOPQ).
  - ALU function codes.
  - stat codes.
  - RNONE.
  - condition ifun codes.
  - the bubble-value constant.
- One sub-module, alu64:
  - inputs: aluA, aluB, alufun.
  - outputs: valE and the {ZF, SF, OF} flags.
  - built on the team's existing 64-bit ripple adder add64bit. SUB is B + ~A + 1, so the adder needs a carry-in variant or an extra increment path.
- The CC register, the condition logic and the E→M register live in execute_stage.

## Test plan
- Reset, then idle → M_icode=1, M_dstE=0xF, M_stat=AOK, cc=3'b100.
- OPq SUB (ifun=1), valA=1, valB=0x8000_0000_0000_0000 → M_valE=0x7FFF_FFFF_FFFF_FFFF one cycle later; cc={0,0,1}.
- OPq ADD, valA=valB=0x7FFF_FFFF_FFFF_FFFF, with m_exc=1 → M_valE=0xFFFF_FFFF_FFFF_FFFE; cc unchanged from its prior value.
- cmovle (icode=2, ifun=1), dstE=3, with cc={0,0,0} → e_cnd=0, e_dstE=0xF. With cc={1,0,0} → e_dstE=3.
- push (icode=A), valB=0x100 → M_valE=0xF8. pop (icode=B), valB=0x100 → M_valE=0x108.
- Load M with a valid instruction, then apply M_stall=1 and M_bubble=1 for 2 cycles → M holds. Release stall with M_bubble=1 → M becomes the bubble. Assert reset during a stall → M becomes the bubble and cc=3'b100.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the E->M bubble constant.
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // ALU function codes (4..F produce zero)
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   // Status codes
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   // Condition ifun codes for cmovXX / jXX
   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   // Condition-code register reset value {ZF, SF, OF}
   localparam logic [2:0] CC_RESET = 3'b100;

   // Control half of the E->M register; the data fields (valE/valA) are
   // width-parameterized and reset to zero alongside this.
   typedef struct packed {
      logic [2:0] stat;
      logic [3:0] icode;
      logic       cnd;
      logic [3:0] dstE;
      logic [3:0] dstM;
   } em_ctl_t;

   localparam em_ctl_t EM_BUBBLE = '{stat: SAOK, icode: INOP, cnd: 1'b0,
                                     dstE: RNONE, dstM: RNONE};

   // Evaluate a branch/cmov condition against cc = {ZF, SF, OF}
   function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
      logic zf, sf, of;
      zf = cc[2];
      sf = cc[1];
      of = cc[0];
      case (ifun)
         C_YES:   cond_eval = 1'b1;
         C_LE:    cond_eval = (sf ^ of) | zf;
         C_L:     cond_eval = sf ^ of;
         C_E:     cond_eval = zf;
         C_NE:    cond_eval = ~zf;
         C_GE:    cond_eval = ~(sf ^ of);
         C_G:     cond_eval = ~(sf ^ of) & ~zf;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/add64bit.sv
// Ripple-carry adder with carry-in; carry-in lets SUB reuse it as B + ~A + 1.
module add64bit #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] w_c;

   assign w_c[0] = i_cin;

   // One full adder per bit; the carry out of the top bit is not needed
   for (genvar g = 0; g < W; g++) begin : g_fa
      assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_c[g];
      if (g < W-1) begin : g_carry
         assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
      end
   end

endmodule

// File: rtl/alu64.sv
// Y86-64 ALU: ADD/SUB/AND/XOR with {ZF, SF, OF} flag generation.
module alu64
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] i_aluA,
   input  logic [W-1:0] i_aluB,
   input  logic [3:0]   i_alufun,
   output logic [W-1:0] o_valE,
   output logic [2:0]   o_flags
);

   logic         w_sub;
   logic [W-1:0] w_opA;
   logic [W-1:0] w_sum;
   logic         w_of;

   // SUB computes B - A as B + ~A + 1 on the shared adder
   assign w_sub = (i_alufun == ALU_SUB);
   assign w_opA = w_sub ? ~i_aluA : i_aluA;

   add64bit #(.W(W)) u_add (
      .i_a   (w_opA),
      .i_b   (i_aluB),
      .i_cin (w_sub),
      .o_sum (w_sum)
   );

   // Result select and signed-overflow detection per function
   always_comb begin
      o_valE = '0;
      w_of   = 1'b0;
      case (i_alufun)
         ALU_ADD: begin
            o_valE = w_sum;
            w_of   = (i_aluA[W-1] == i_aluB[W-1]) && (w_sum[W-1] != i_aluA[W-1]);
         end
         ALU_SUB: begin
            o_valE = w_sum;
            w_of   = (i_aluA[W-1] != i_aluB[W-1]) && (w_sum[W-1] != i_aluB[W-1]);
         end
         ALU_AND: o_valE = i_aluA & i_aluB;
         ALU_XOR: o_valE = i_aluA ^ i_aluB;
         default: o_valE = '0;
      endcase
   end

   assign o_flags = {(o_valE == '0), o_valE[W-1], w_of};

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, E->M register.
module execute_stage
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   E_stat,
   input  logic [3:0]   E_icode,
   input  logic [3:0]   E_ifun,
   input  logic [W-1:0] E_valA,
   input  logic [W-1:0] E_valB,
   input  logic [W-1:0] E_valC,
   input  logic [3:0]   E_dstE,
   input  logic [3:0]   E_dstM,
   input  logic         m_exc,
   input  logic         W_exc,
   input  logic         M_stall,
   input  logic         M_bubble,
   output logic [W-1:0] e_valE,
   output logic [3:0]   e_dstE,
   output logic         e_cnd,
   output logic [2:0]   M_stat,
   output logic [3:0]   M_icode,
   output logic         M_cnd,
   output logic [W-1:0] M_valE,
   output logic [W-1:0] M_valA,
   output logic [3:0]   M_dstE,
   output logic [3:0]   M_dstM,
   output logic [2:0]   cc
);

   logic [W-1:0] w_aluA;
   logic [W-1:0] w_aluB;
   logic [3:0]   w_alufun;
   logic [2:0]   w_flags;
   logic         w_cc_upd;

   logic [2:0]   r_cc;
   em_ctl_t      r_ctl;
   logic [W-1:0] r_valE;
   logic [W-1:0] r_valA;

   // ALU operand A: register value, immediate, or stack-pointer step
   always_comb begin
      w_aluA = '0;
      case (E_icode)
         IRRMOVQ, IOPQ:            w_aluA = E_valA;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: w_aluA = E_valC;
         ICALL, IPUSHQ:            w_aluA = -W'(8);
         IRET, IPOPQ:              w_aluA = W'(8);
         default:                  w_aluA = '0;
      endcase
   end

   // ALU operand B: valB for memory/stack/OPq, zero for moves
   always_comb begin
      w_aluB = '0;
      case (E_icode)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: w_aluB = E_valB;
         default:                                          w_aluB = '0;
      endcase
   end

   assign w_alufun = (E_icode == IOPQ) ? E_ifun : ALU_ADD;

   alu64 #(.W(W)) u_alu (
      .i_aluA   (w_aluA),
      .i_aluB   (w_aluB),
      .i_alufun (w_alufun),
      .o_valE   (e_valE),
      .o_flags  (w_flags)
   );

   // Flags are only committed by a clean OPq; younger excepting stages block it
   assign w_cc_upd = (E_icode == IOPQ) && (E_stat == SAOK) && !m_exc && !W_exc;

   // Condition-code register; independent of E->M stall/bubble
   always_ff @(posedge clk) begin
      if (reset)         r_cc <= CC_RESET;
      else if (w_cc_upd) r_cc <= w_flags;
   end

   assign cc     = r_cc;
   assign e_cnd  = ((E_icode == IRRMOVQ) || (E_icode == IJXX)) ? cond_eval(E_ifun, r_cc) : 1'b0;
   assign e_dstE = ((E_icode == IRRMOVQ) && !e_cnd) ? RNONE : E_dstE;

   // E->M pipeline register: reset > stall (hold) > bubble > load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctl  <= EM_BUBBLE;
         r_valE <= '0;
         r_valA <= '0;
      end else if (M_stall) begin
         r_ctl  <= r_ctl;
         r_valE <= r_valE;
         r_valA <= r_valA;
      end else if (M_bubble) begin
         r_ctl  <= EM_BUBBLE;
         r_valE <= '0;
         r_valA <= '0;
      end else begin
         r_ctl  <= '{stat: E_stat, icode: E_icode, cnd: e_cnd, dstE: e_dstE, dstM: E_dstM};
         r_valE <= e_valE;
         r_valA <= E_valA;
      end
   end

   assign M_stat  = r_ctl.stat;
   assign M_icode = r_ctl.icode;
   assign M_cnd   = r_ctl.cnd;
   assign M_dstE  = r_ctl.dstE;
   assign M_dstM  = r_ctl.dstM;
   assign M_valE  = r_valE;
   assign M_valA  = r_valA;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

   logic        clk, reset;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
   logic [63:0] E_valA, E_valB, E_valC;
   logic        m_exc, W_exc, M_stall, M_bubble;
   logic [63:0] e_valE, M_valE, M_valA;
   logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
   logic        e_cnd, M_cnd;
   logic [2:0]  M_stat, cc;

   int checks = 0;
   int errors = 0;

   execute_stage #(.W(64)) dut (
      .clk(clk), .reset(reset),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
      .E_dstE(E_dstE), .E_dstM(E_dstM),
      .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble),
      .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
      .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .cc(cc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [3:0] de, input logic [3:0] dm);
      E_stat = st; E_icode = ic; E_ifun = fn;
      E_valA = a; E_valB = b; E_valC = c;
      E_dstE = de; E_dstM = dm;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; m_exc = 0; W_exc = 0; M_stall = 0; M_bubble = 0;
      drive(3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      tick();
      reset = 1'b0;
      tick();
      checks++; if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h exp 1", M_icode); end
      checks++; if (M_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE got %h exp f", M_dstE); end
      checks++; if (M_stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %0d exp 1", M_stat); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL reset_cc got %b exp 100", cc); end
      checks++; if (M_valE !== 64'h0) begin errors++; $display("FAIL reset_valE got %h exp 0", M_valE); end
   endtask

   task automatic test_opq_sub();
      drive(3'd1, 4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h2, 4'hF);
      checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_e_valE got %h exp 7fffffffffffffff", e_valE); end
      tick();
      checks++; if (M_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_M_valE got %h exp 7fffffffffffffff", M_valE); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL sub_cc got %b exp 001", cc); end
      checks++; if (M_dstE !== 4'h2 || M_icode !== 4'h6) begin errors++; $display("FAIL sub_fields got %h/%h exp 2/6", M_dstE, M_icode); end
   endtask

   task automatic test_exc();
      m_exc = 1'b1;
      drive(3'd1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h4, 4'hF);
      tick();
      m_exc = 1'b0;
      checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mexc_valE got %h exp fffffffffffffffe", M_valE); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL mexc_cc got %b exp 001", cc); end
      W_exc = 1'b1;
      drive(3'd1, 4'h6, 4'h3, 64'h3, 64'h3, 64'h0, 4'h4, 4'hF);
      tick();
      W_exc = 1'b0;
      checks++; if (M_valE !== 64'h0) begin errors++; $display("FAIL wexc_valE got %h exp 0", M_valE); end
      checks++; if (cc !== 3'b001) begin errors++; $display("FAIL wexc_cc got %b exp 001", cc); end
      drive(3'd3, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'hF);
      tick();
      checks++; if (cc !== 3'b001 || M_stat !== 3'd3) begin errors++; $display("FAIL badstat_cc got %b/%0d exp 001/3", cc, M_stat); end
   endtask

   task automatic test_cmov();
      drive(3'd1, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h4, 4'hF);
      tick();
      checks++; if (cc !== 3'b000) begin errors++; $display("FAIL add_cc got %b exp 000", cc); end
      drive(3'd1, 4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3, 4'hF);
      checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin errors++; $display("FAIL cmovle_nt got %b/%h exp 0/f", e_cnd, e_dstE); end
      tick();
      checks++; if (M_dstE !== 4'hF || M_cnd !== 1'b0 || M_valE !== 64'h55) begin errors++; $display("FAIL cmovle_nt_M got %h/%b/%h exp f/0/55", M_dstE, M_cnd, M_valE); end
      drive(3'd1, 4'h6, 4'h3, 64'h5, 64'h5, 64'h0, 4'h4, 4'hF);
      tick();
      drive(3'd1, 4'h2, 4'h1, 64'h55, 64'h0, 64'h0, 4'h3, 4'hF);
      checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h3) begin errors++; $display("FAIL cmovle_t got %b/%h exp 1/3", e_cnd, e_dstE); end
      drive(3'd1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL jl_zf got %b exp 0", e_cnd); end
      tick();
      drive(3'd1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h4, 4'hF);
      tick();
      checks++; if (cc !== 3'b010 || M_valE !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL neg_cc got %b/%h exp 010/ffffffffffffffff", cc, M_valE); end
      drive(3'd1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      checks++; if (e_cnd !== 1'b1) begin errors++; $display("FAIL jl_sf got %b exp 1", e_cnd); end
      drive(3'd1, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL jg_sf got %b exp 0", e_cnd); end
      drive(3'd1, 4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
      checks++; if (e_cnd !== 1'b0) begin errors++; $display("FAIL j_ifun7 got %b exp 0", e_cnd); end
      drive(3'd1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h9, 4'h1, 4'hF);
      checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'h1) begin errors++; $display("FAIL irmov_cnd got %b/%h exp 0/1", e_cnd, e_dstE); end
   endtask

   task automatic test_push_pop();
      drive(3'd1, 4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'hF);
      checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL push_e_valE got %h exp f8", e_valE); end
      tick();
      checks++; if (M_valE !== 64'hF8) begin errors++; $display("FAIL push_M_valE got %h exp f8", M_valE); end
      drive(3'd1, 4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 4'h7);
      tick();
      checks++; if (M_valE !== 64'h108 || M_dstM !== 4'h7) begin errors++; $display("FAIL pop got %h/%h exp 108/7", M_valE, M_dstM); end
      drive(3'd1, 4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF);
      checks++; if (e_valE !== 64'h1F8) begin errors++; $display("FAIL call got %h exp 1f8", e_valE); end
      drive(3'd1, 4'h5, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF, 4'h2);
      checks++; if (e_valE !== 64'h30) begin errors++; $display("FAIL mrmov got %h exp 30", e_valE); end
      drive(3'd1, 4'h2, 4'h0, 64'hAB, 64'h99, 64'h0, 4'h6, 4'hF);
      tick();
      checks++; if (M_valE !== 64'hAB || M_dstE !== 4'h6 || M_valA !== 64'hAB) begin errors++; $display("FAIL rrmov got %h/%h/%h exp ab/6/ab", M_valE, M_dstE, M_valA); end
   endtask

   task automatic test_stall_bubble();
      drive(3'd1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h5, 4'hF);
      tick();
      checks++; if (M_valE !== 64'h1234 || M_icode !== 4'h3) begin errors++; $display("FAIL load got %h/%h exp 1234/3", M_valE, M_icode); end
      M_stall = 1'b1; M_bubble = 1'b1;
      drive(3'd1, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2, 4'hF);
      tick();
      tick();
      checks++; if (M_valE !== 64'h1234 || M_icode !== 4'h3 || M_dstE !== 4'h5) begin errors++; $display("FAIL stall_hold got %h/%h/%h exp 1234/3/5", M_valE, M_icode, M_dstE); end
      checks++; if (cc !== 3'b000) begin errors++; $display("FAIL stall_cc got %b exp 000", cc); end
      M_stall = 1'b0;
      tick();
      checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valE !== 64'h0 || M_stat !== 3'd1) begin errors++; $display("FAIL bubble got %h/%h/%h exp 1/f/0", M_icode, M_dstE, M_valE); end
      M_bubble = 1'b0;
      drive(3'd1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h77, 4'h5, 4'hF);
      tick();
      checks++; if (M_valE !== 64'h77) begin errors++; $display("FAIL reload got %h exp 77", M_valE); end
      M_stall = 1'b1; reset = 1'b1;
      drive(3'd1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 4'h2, 4'hF);
      tick();
      reset = 1'b0; M_stall = 1'b0;
      checks++; if (M_icode !== 4'h1 || M_valE !== 64'h0 || M_dstE !== 4'hF) begin errors++; $display("FAIL rst_stall got %h/%h/%h exp 1/0/f", M_icode, M_valE, M_dstE); end
      checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rst_stall_cc got %b exp 100", cc); end
   endtask

   initial begin
      test_reset();
      test_opq_sub();
      test_exc();
      test_cmov();
      test_push_pop();
      test_stall_bubble();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
